// File: rtl/lighting_pkg.sv
// Shared lighting controller definitions: state encodings and default constants.
package lighting_pkg;

  localparam int unsigned LIGHT_STATE_W       = 2;
  localparam int unsigned DEFAULT_RESET_STATE = 0;
  localparam int unsigned DEFAULT_DWELL_W     = 8;

  // Lamp controller state encodings
  typedef enum logic [LIGHT_STATE_W-1:0] {
    IDLE      = 2'd0,
    ON        = 2'd1,
    DIM       = 2'd2,
    OFF_DELAY = 2'd3
  } light_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat decodes the registered count.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, increment stops at all-ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign sat   = &count_q;

endmodule

// File: rtl/lighting_state_reg.sv
// Registered half of a lighting FSM: enable, sync clear, illegal recovery,
// previous-state tracking, change pulse and saturating dwell counter.
module lighting_state_reg
  import lighting_pkg::*;
#(
  parameter int unsigned STATE_W     = LIGHT_STATE_W,
  parameter int unsigned NUM_STATES  = 4,
  parameter int unsigned RESET_STATE = DEFAULT_RESET_STATE,
  parameter int unsigned DWELL_W     = DEFAULT_DWELL_W
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Enable,
  input  logic               Sync_Clear,
  input  logic [STATE_W-1:0] Next_State,
  output logic [STATE_W-1:0] Present_State,
  output logic [STATE_W-1:0] Previous_State,
  output logic               State_Changed,
  output logic [DWELL_W-1:0] Dwell_Count,
  output logic               Dwell_Sat,
  output logic               Illegal
);

  // Parameter legality checks at elaboration
  if (STATE_W < 1 || STATE_W > 31) begin : g_bad_state_w
    $error("lighting_state_reg: STATE_W must be 1..31");
  end
  if (NUM_STATES < 1 || 64'(NUM_STATES) > (64'(1) << STATE_W)) begin : g_bad_num_states
    $error("lighting_state_reg: NUM_STATES must be 1..2**STATE_W");
  end
  if (RESET_STATE >= NUM_STATES) begin : g_bad_reset_state
    $error("lighting_state_reg: RESET_STATE must be below NUM_STATES");
  end
  if (DWELL_W < 1) begin : g_bad_dwell_w
    $error("lighting_state_reg: DWELL_W must be at least 1");
  end

  localparam logic [STATE_W-1:0] RST_ENC = STATE_W'(RESET_STATE);

  logic [STATE_W-1:0] present_q, present_d;
  logic [STATE_W-1:0] previous_q, previous_d;
  logic               changed_q, changed_d;
  logic               illegal_q, illegal_d;
  logic               next_legal;
  logic [STATE_W-1:0] cand;
  logic               dwell_clr;
  logic               dwell_inc;

  // Out-of-range requests fall back to the reset state
  assign next_legal = (32'(Next_State) < NUM_STATES);
  assign cand       = next_legal ? Next_State : RST_ENC;

  // Next-state and dwell control, Sync_Clear over Enable
  always_comb begin
    present_d  = present_q;
    previous_d = previous_q;
    changed_d  = 1'b0;
    illegal_d  = illegal_q;
    dwell_clr  = 1'b0;
    dwell_inc  = 1'b0;
    if (Sync_Clear) begin
      present_d  = RST_ENC;
      previous_d = present_q;
      changed_d  = (present_q != RST_ENC);
      illegal_d  = 1'b0;
      dwell_clr  = 1'b1;
    end else if (Enable) begin
      illegal_d = illegal_q | ~next_legal;
      if (cand != present_q) begin
        present_d  = cand;
        previous_d = present_q;
        changed_d  = 1'b1;
        dwell_clr  = 1'b1;
      end else begin
        dwell_inc = 1'b1;
      end
    end
  end

  // State, history and flag registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      present_q  <= RST_ENC;
      previous_q <= RST_ENC;
      changed_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      present_q  <= present_d;
      previous_q <= previous_d;
      changed_q  <= changed_d;
      illegal_q  <= illegal_d;
    end
  end

  sat_counter #(
    .WIDTH (DWELL_W)
  ) u_dwell (
    .Clock (Clock),
    .Reset (Reset),
    .clr   (dwell_clr),
    .inc   (dwell_inc),
    .count (Dwell_Count),
    .sat   (Dwell_Sat)
  );

  assign Present_State  = present_q;
  assign Previous_State = previous_q;
  assign State_Changed  = changed_q;
  assign Illegal        = illegal_q;

endmodule

// File: doc/lighting_state_reg.md
# lighting_state_reg

Parametrised state register for the automatic-lighting controllers. It is the registered half of every lighting FSM and accepts Next_State from the controller's combinational next-state logic. It adds the following to a plain state flop:
- a tick/hold enable;
- a synchronous return-to-idle;
- illegal-state recovery with a sticky flag;
- previous-state tracking and a state-change pulse;
- a saturating dwell counter, so lamp on/off timers can be built directly off time-in-state.

## Interface
- STATE_W, 2, width of the state encoding.
- NUM_STATES, 4, number of legal encodings 0..NUM_STATES-1; must satisfy 1 ≤ NUM_STATES ≤ 2**STATE_W.
- RESET_STATE, 0, state loaded on reset, on Sync_Clear and on illegal input; must be < NUM_STATES.
- DWELL_W, 8, width of the dwell counter.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  reset, asynchronous, active-high.
- Enable  in  1  state-update/tick qualifier.
- Sync_Clear  in  1  synchronous return to RESET_STATE; priority over Enable.
- Next_State  in  STATE_W  requested next state.
- Present_State  out  STATE_W  registered current state.
- Previous_State  out  STATE_W  state held before the last transition.
- State_Changed  out  1  one-cycle registered pulse on any transition.
- Dwell_Count  out  DWELL_W  enabled edges spent in the current state, saturating.
- Dwell_Sat  out  1  Dwell_Count equals all-ones.
- Illegal  out  1  sticky flag: an out-of-range Next_State was sampled.

## Operation
- Reset (asynchronous, takes effect with no clock edge) sets:
  - Present_State = Previous_State = RESET_STATE;
  - State_Changed = 0, Dwell_Count = 0, Illegal = 0.
- Rules are evaluated at each rising edge in this priority order.
- **Sync_Clear = 1** (Enable ignored):
  - Present_State ← RESET_STATE, Previous_State ← Present_State;
  - State_Changed ← (Present_State ≠ RESET_STATE);
  - Dwell_Count ← 0, Illegal ← 0.
- **Enable = 1:**
  - cand = Next_State if Next_State < NUM_STATES, else RESET_STATE;
  - Illegal ← Illegal | (Next_State ≥ NUM_STATES).
  - If cand ≠ Present_State: Present_State ← cand, Previous_State ← Present_State, State_Changed ← 1, Dwell_Count ← 0.
  - Else: State_Changed ← 0, Dwell_Count ← min(Dwell_Count+1, 2**DWELL_W−1).
- **Enable = 0:**
  - Present_State, Previous_State, Dwell_Count and Illegal hold; State_Changed ← 0.
  - Next_State is not sampled, so no illegal detection occurs.
- Arithmetic: Dwell_Count never wraps, and increments only on enabled edges with no state change.
- Illegal clears only on Reset or Sync_Clear.

## Timing
- Latency: one edge from Next_State/Enable to Present_State. No combinational path from inputs to outputs, except Dwell_Sat, which decodes registered Dwell_Count only.
- State_Changed:
  - is high for exactly the one cycle following the transitioning edge;
  - back-to-back transitions produce a pulse each cycle.
- Dwell_Count:
  - reads 0 in the cycle after a transition;
  - reads 1 after the first same-state enabled edge.
- Simultaneous Sync_Clear and illegal Next_State: Illegal ends at 0 (the clear wins).
- Illegal input while already in RESET_STATE: no transition and no pulse; Dwell_Count increments; Illegal sets.
- Reset asserted mid-count or mid-pulse: all outputs return to reset values immediately. The first edge after release is evaluated normally.

## Structure
- Shared package lighting_pkg holds:
  - the lighting state encodings (IDLE, ON, DIM, OFF_DELAY) as a STATE_W=2 enum;
  - the default RESET_STATE and DWELL_W constants.
- One sub-module, sat_counter (parameter WIDTH; ports Clock, Reset, clr, inc, count, sat), implements Dwell_Count/Dwell_Sat.
- Parameter legality is checked by elaboration-time assertions.

## Test plan
Configuration for all scenarios: STATE_W=2, NUM_STATES=3, RESET_STATE=0, DWELL_W=4.
- Async reset mid-operation: Present=2, Dwell=5, Illegal=1; pulse Reset between edges. Required: all outputs at reset values before the next edge.
- Transition: Enable=1, Next 0→1. Required: Present=1, Previous=0, State_Changed high for 1 cycle, Dwell=0.
- Saturation: hold Next=1, Enable=1 for 20 edges. Required: Dwell 1..15, then stays 15; Dwell_Sat=1 from the 15th edge; no wrap.
- Illegal recovery: from state 1, Next=3, Enable=1. Required: Present=0, Previous=1, pulse, Illegal=1; Illegal stays 1 after later legal Next=2.
- Hold: Enable=0, Next=2 for 5 edges in state 1 with Dwell=4. Required: Present=1, Dwell=4, State_Changed=0 throughout.
- Clear priority: state 1, Illegal=1; Sync_Clear=1, Enable=1, Next=2. Required: Present=0, Previous=1, pulse, Dwell=0, Illegal=0.
